// File: rtl/regfile_param_if.sv
// Register file bus: write, reserve, clear and the two read ports.
// The master side drives requests and read addresses; the slave side
// (the register file) answers with read data, busy flags and sweep status.
`timescale 1ns/1ps
interface regfile_param_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) ();
  logic              ctrl_writeEnable;
  logic [ADDR_W-1:0] ctrl_writeReg;
  logic [WIDTH-1:0]  data_writeReg;
  logic              ctrl_reserve;
  logic [ADDR_W-1:0] ctrl_reserveReg;
  logic              ctrl_clear;
  logic [ADDR_W-1:0] ctrl_readRegA;
  logic [ADDR_W-1:0] ctrl_readRegB;
  logic [WIDTH-1:0]  data_readRegA;
  logic [WIDTH-1:0]  data_readRegB;
  logic              busy_readRegA;
  logic              busy_readRegB;
  logic              clear_busy;

  modport master (
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    output ctrl_reserve, ctrl_reserveReg, ctrl_clear,
    output ctrl_readRegA, ctrl_readRegB,
    input  data_readRegA, data_readRegB,
    input  busy_readRegA, busy_readRegB, clear_busy
  );

  modport slave (
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    input  ctrl_reserve, ctrl_reserveReg, ctrl_clear,
    input  ctrl_readRegA, ctrl_readRegB,
    output data_readRegA, data_readRegB,
    output busy_readRegA, busy_readRegB, clear_busy
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file with optional hardwired-zero register 0,
// optional write-to-read forwarding, a per-register busy scoreboard and a
// sequencer that zeroes every location one per cycle without a reset.
`timescale 1ns/1ps
module regfile_param #(
  parameter int WIDTH     = 32,
  parameter int ADDR_W    = 5,
  parameter int ZERO_REG0 = 1,
  parameter int BYPASS    = 1
) (
  input  logic           clock,
  input  logic           ctrl_reset_n,
  regfile_param_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] counter_q, counter_d;
  logic [WIDTH-1:0]  regFile_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;

  logic              isIdle;
  logic              writeValid;
  logic              reserveValid;
  logic              bypassOn;

  logic [ADDR_W-1:0] rdAddr [2];
  logic [WIDTH-1:0]  rdData [2];
  logic              rdBusy [2];

  // Qualify requests: only accepted in IDLE, and never against a hardwired r0
  always_comb begin
    isIdle       = (state_q == IDLE);
    writeValid   = isIdle && bus.ctrl_writeEnable &&
                   !((ZERO_REG0 != 0) && (bus.ctrl_writeReg == '0));
    reserveValid = isIdle && bus.ctrl_reserve &&
                   !((ZERO_REG0 != 0) && (bus.ctrl_reserveReg == '0));
    bypassOn     = (BYPASS != 0) && ctrl_reset_n && writeValid;
  end

  // Sweep sequencer state and address counter
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q   <= IDLE;
      counter_q <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
    end
  end

  // Next-state: start on ctrl_clear, walk every address, wrap back to IDLE
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    case (state_q)
      IDLE: begin
        if (bus.ctrl_clear) begin
          state_d   = SWEEP;
          counter_d = '0;
        end
      end
      SWEEP: begin
        counter_d = counter_q + 1'b1;
        if (counter_q == LAST_ADDR) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        counter_d = '0;
      end
    endcase
  end

  // Storage: sweep zeroes one location per cycle, otherwise accept writes
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regFile_q[i] <= '0;
      end
    end else if (state_q == SWEEP) begin
      regFile_q[counter_q] <= '0;
    end else if (writeValid) begin
      regFile_q[bus.ctrl_writeReg] <= bus.data_writeReg;
    end
  end

  // Scoreboard: write retires a producer, reserve (applied last) wins a tie
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      busy_q <= '0;
    end else if (state_q == SWEEP) begin
      busy_q[counter_q] <= 1'b0;
    end else begin
      if (writeValid) begin
        busy_q[bus.ctrl_writeReg] <= 1'b0;
      end
      if (reserveValid) begin
        busy_q[bus.ctrl_reserveReg] <= 1'b1;
      end
    end
  end

  assign rdAddr[0] = bus.ctrl_readRegA;
  assign rdAddr[1] = bus.ctrl_readRegB;

  // Read ports: stored value, forwarded write data, or a hardwired zero
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdData[p] = regFile_q[rdAddr[p]];
      rdBusy[p] = busy_q[rdAddr[p]];
      if (bypassOn && (rdAddr[p] == bus.ctrl_writeReg)) begin
        rdData[p] = bus.data_writeReg;
        if (!(reserveValid && (bus.ctrl_reserveReg == rdAddr[p]))) begin
          rdBusy[p] = 1'b0;
        end
      end
      if ((ZERO_REG0 != 0) && (rdAddr[p] == '0)) begin
        rdData[p] = '0;
        rdBusy[p] = 1'b0;
      end
    end
  end

  assign bus.data_readRegA = rdData[0];
  assign bus.data_readRegB = rdData[1];
  assign bus.busy_readRegA = rdBusy[0];
  assign bus.busy_readRegB = rdBusy[1];
  assign bus.clear_busy    = (state_q == SWEEP);

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: a 32x32 instance with zero-r0 and bypass, and a
// 8x16 instance with both disabled. Stimulus queues hand-computed
// expectations; a monitor process samples the DUT and scores them.
`timescale 1ns/1ps
module tb_regfile_param;

   logic clock = 1'b0;
   logic rstN;

   always #5 clock = ~clock;

   regfile_param_if #(.WIDTH(32), .ADDR_W(5)) busA ();
   regfile_param_if #(.WIDTH(16), .ADDR_W(3)) busB ();

   regfile_param #(.WIDTH(32), .ADDR_W(5), .ZERO_REG0(1), .BYPASS(1)) dutA (
      .clock(clock),
      .ctrl_reset_n(rstN),
      .bus(busA.slave)
   );

   regfile_param #(.WIDTH(16), .ADDR_W(3), .ZERO_REG0(0), .BYPASS(0)) dutB (
      .clock(clock),
      .ctrl_reset_n(rstN),
      .bus(busB.slave)
   );

   typedef struct {
      string       name;
      int          id;
      logic [31:0] measured;
      logic [31:0] exp;
   } exp_t;

   exp_t expQ[$];
   int   reqCount     = 0;
   int   ackCount     = 0;
   int   checksDone   = 0;
   int   checksPassed = 0;

   // Select which DUT output an expectation refers to
   function automatic logic [31:0] sampleDut(input int id, input logic [31:0] measured);
      case (id)
         0:       return busA.data_readRegA;
         1:       return busA.data_readRegB;
         2:       return {31'b0, busA.busy_readRegA};
         3:       return {31'b0, busA.busy_readRegB};
         4:       return {31'b0, busA.clear_busy};
         5:       return {16'b0, busB.data_readRegA};
         6:       return {16'b0, busB.data_readRegB};
         7:       return {31'b0, busB.busy_readRegA};
         8:       return {31'b0, busB.clear_busy};
         default: return measured;
      endcase
   endfunction

   // Monitor: whenever a sample is requested, drain and score the queue
   initial begin
      exp_t e;
      logic [31:0] act;
      forever begin
         wait (reqCount != ackCount);
         while (expQ.size() > 0) begin
            e   = expQ.pop_front();
            act = sampleDut(e.id, e.measured);
            checksDone++;
            if (act === e.exp) begin
               checksPassed++;
            end else begin
               $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
            end
         end
         ackCount = reqCount;
      end
   end

   task automatic checkOutput(input string name, input int id,
                              input logic [31:0] exp, input logic [31:0] measured);
      exp_t e;
      e.name     = name;
      e.id       = id;
      e.exp      = exp;
      e.measured = measured;
      expQ.push_back(e);
      reqCount++;
      wait (ackCount == reqCount);
   endtask

   task automatic applyStimulus(input bit we, input int wr, input logic [31:0] wd,
                                input bit rsv, input int rr, input bit clr,
                                input int ra, input int rb);
      busA.ctrl_writeEnable = we;
      busA.ctrl_writeReg    = 5'(wr);
      busA.data_writeReg    = wd;
      busA.ctrl_reserve     = rsv;
      busA.ctrl_reserveReg  = 5'(rr);
      busA.ctrl_clear       = clr;
      busA.ctrl_readRegA    = 5'(ra);
      busA.ctrl_readRegB    = 5'(rb);
   endtask

   task automatic applyStimulusB(input bit we, input int wr, input logic [15:0] wd,
                                 input bit rsv, input int rr, input bit clr,
                                 input int ra, input int rb);
      busB.ctrl_writeEnable = we;
      busB.ctrl_writeReg    = 3'(wr);
      busB.data_writeReg    = wd;
      busB.ctrl_reserve     = rsv;
      busB.ctrl_reserveReg  = 3'(rr);
      busB.ctrl_clear       = clr;
      busB.ctrl_readRegA    = 3'(ra);
      busB.ctrl_readRegB    = 3'(rb);
   endtask

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   // Global time limit so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Directed scenario sequence
   initial begin
      int k;
      rstN = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulusB(0, 0, 0, 0, 0, 0, 0, 0);
      #7;

      // Reset state on every address
      for (int i = 0; i < 32; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, i, 31 - i);
         #1;
         checkOutput($sformatf("rst_dataA_r%0d", i), 0, 32'h0, 0);
         checkOutput($sformatf("rst_dataB_r%0d", 31 - i), 1, 32'h0, 0);
         checkOutput($sformatf("rst_busyA_r%0d", i), 2, 32'h0, 0);
         checkOutput($sformatf("rst_busyB_r%0d", 31 - i), 3, 32'h0, 0);
      end
      checkOutput("rst_clearBusyA", 4, 32'h0, 0);
      checkOutput("rst_clearBusyB", 8, 32'h0, 0);
      checkOutput("rst_cfgB_dataA", 5, 32'h0, 0);
      @(negedge clock);
      rstN = 1'b1;
      tick();

      // Write with bypass, then stored value; r0 stays zero
      applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0);
      #1;
      checkOutput("bypass_r5_data", 0, 32'hDEADBEEF, 0);
      checkOutput("bypass_r5_busy", 2, 32'h0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 5, 0);
      #1;
      checkOutput("stored_r5", 0, 32'hDEADBEEF, 0);
      checksDone++;
      if (busA.data_readRegA === 32'hDEADBEEF) begin
         checksPassed++;
      end else begin
         $display("[TB] FAIL direct_stored_r5: got 0x%0h", busA.data_readRegA);
      end
      applyStimulus(1, 0, 32'h12345678, 0, 0, 0, 0, 5);
      #1;
      checkOutput("r0_write_bypass", 0, 32'h0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 5);
      #1;
      checkOutput("r0_write_dropped", 0, 32'h0, 0);
      checkOutput("r5_on_portB", 1, 32'hDEADBEEF, 0);

      // Scoreboard: reserve, retire by write, reserve wins tie
      applyStimulus(0, 0, 0, 1, 7, 0, 7, 7);
      #1;
      checkOutput("reserve_r7_before_edge", 2, 32'h0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 7, 7);
      #1;
      checkOutput("reserve_r7_busyA", 2, 32'h1, 0);
      checkOutput("reserve_r7_busyB", 3, 32'h1, 0);
      applyStimulus(1, 7, 32'hA5A5A5A5, 0, 0, 0, 7, 7);
      #1;
      checkOutput("write_r7_bypass_busy", 2, 32'h0, 0);
      checkOutput("write_r7_bypass_data", 0, 32'hA5A5A5A5, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 7, 7);
      #1;
      checkOutput("write_r7_busy_cleared", 2, 32'h0, 0);
      checkOutput("write_r7_data", 0, 32'hA5A5A5A5, 0);
      applyStimulus(1, 7, 32'h1234ABCD, 1, 7, 0, 7, 7);
      #1;
      checkOutput("tie_r7_bypass_data", 0, 32'h1234ABCD, 0);
      checkOutput("tie_r7_busy_before", 2, 32'h0, 0);
      tick();
      applyStimulus(0, 0, 0, 1, 0, 0, 7, 0);
      #1;
      checkOutput("tie_r7_busy", 2, 32'h1, 0);
      checkOutput("tie_r7_data", 0, 32'h1234ABCD, 0);
      checksDone++;
      if (busA.busy_readRegA === 1'b1) begin
         checksPassed++;
      end else begin
         $display("[TB] FAIL direct_tie_r7_busy: got %b", busA.busy_readRegA);
      end
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 7, 0);
      #1;
      checkOutput("reserve_r0_dropped", 3, 32'h0, 0);

      // Load r1..r31 with their index
      for (int i = 1; i < 32; i++) begin
         applyStimulus(1, i, 32'(i), 0, 0, 0, 0, 0);
         tick();
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 3, 31);
      #1;
      checkOutput("load_r3", 0, 32'd3, 0);
      checkOutput("load_r31", 1, 32'd31, 0);
      checkOutput("load_r31_busy", 3, 32'h0, 0);

      // Clear with same-cycle write and reserve, then run the sweep
      applyStimulus(1, 2, 32'h2222, 1, 12, 1, 2, 12);
      #1;
      checkOutput("clear_start_not_busy", 4, 32'h0, 0);
      tick();
      k = 0;
      while (busA.clear_busy === 1'b1 && k < 100) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 3, 12);
         if (k == 0) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 2, 12);
            #1;
            checkOutput("sweep_clear_cycle_write", 0, 32'h2222, 0);
            checkOutput("sweep_clear_cycle_reserve", 3, 32'h1, 0);
         end
         if (k == 1) begin
            applyStimulus(1, 3, 32'hFFFFFFFF, 0, 0, 0, 3, 12);
            #1;
            checkOutput("sweep_bypass_suppressed", 0, 32'd3, 0);
         end
         if (k == 2) begin
            #1;
            checkOutput("sweep_write_dropped", 0, 32'd3, 0);
         end
         if (k == 25) applyStimulus(0, 0, 0, 1, 20, 0, 3, 12);
         if (k == 30) applyStimulus(0, 0, 0, 0, 0, 1, 3, 12);
         tick();
         k++;
      end
      checkOutput("sweep_length_32", 99, 32'd32, 32'(k));
      for (int i = 0; i < 32; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, i, 31 - i);
         #1;
         checkOutput($sformatf("swept_dataA_r%0d", i), 0, 32'h0, 0);
         checkOutput($sformatf("swept_busyA_r%0d", i), 2, 32'h0, 0);
      end
      checkOutput("sweep_not_restarted", 4, 32'h0, 0);

      // Reset in the middle of a sweep
      applyStimulus(1, 30, 32'h30, 0, 0, 0, 30, 9);
      tick();
      applyStimulus(1, 9, 32'h99, 0, 0, 0, 30, 9);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 1, 30, 9);
      #1;
      checkOutput("pre_sweep_r30", 0, 32'h30, 0);
      tick();
      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 30, 9);
         tick();
      end
      applyStimulus(1, 30, 32'h77, 0, 0, 0, 30, 9);
      #1;
      rstN = 1'b0;
      #1;
      checkOutput("midsweep_rst_clearBusy", 4, 32'h0, 0);
      checkOutput("midsweep_rst_r30_no_bypass", 0, 32'h0, 0);
      checkOutput("midsweep_rst_r9", 1, 32'h0, 0);
      checkOutput("midsweep_rst_busyA", 2, 32'h0, 0);
      applyStimulus(1, 9, 32'h55, 0, 0, 0, 9, 30);
      @(negedge clock);
      rstN = 1'b1;
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 9, 30);
      #1;
      checkOutput("post_rst_write_r9", 0, 32'h55, 0);
      checkOutput("post_rst_r30", 1, 32'h0, 0);
      checkOutput("post_rst_idle", 4, 32'h0, 0);

      // Narrow config: ordinary r0, no bypass, 8-deep sweep
      applyStimulusB(1, 0, 16'hBEEF, 0, 0, 0, 0, 3);
      #1;
      checkOutput("cfgB_r0_old_value", 5, 32'h0, 0);
      tick();
      applyStimulusB(1, 3, 16'h1234, 0, 0, 0, 0, 3);
      #1;
      checkOutput("cfgB_r0_stored", 5, 32'hBEEF, 0);
      checksDone++;
      if (busB.data_readRegA === 16'hBEEF) begin
         checksPassed++;
      end else begin
         $display("[TB] FAIL direct_cfgB_r0_stored: got 0x%0h", busB.data_readRegA);
      end
      checkOutput("cfgB_r3_no_bypass", 6, 32'h0, 0);
      tick();
      applyStimulusB(0, 0, 0, 1, 0, 0, 0, 3);
      #1;
      checkOutput("cfgB_r3_stored", 6, 32'h1234, 0);
      tick();
      applyStimulusB(0, 0, 0, 0, 0, 1, 0, 3);
      #1;
      checkOutput("cfgB_r0_busy", 7, 32'h1, 0);
      tick();
      applyStimulusB(0, 0, 0, 0, 0, 0, 0, 3);
      k = 0;
      while (busB.clear_busy === 1'b1 && k < 100) begin
         tick();
         k++;
      end
      checkOutput("cfgB_sweep_length_8", 99, 32'd8, 32'(k));
      #1;
      checkOutput("cfgB_swept_r0", 5, 32'h0, 0);
      checkOutput("cfgB_swept_r3", 6, 32'h0, 0);
      checkOutput("cfgB_swept_busy_r0", 7, 32'h0, 0);

      $display("[TB] %0d/%0d checks passed", checksPassed, checksDone);
      $finish;
   end

endmodule
